// File: rtl/comet2_pkg.sv
// Shared types for the COMET II memory master: request ops, FSM states and the
// opcode-byte tables used to work out instruction length and legality.
package comet2_pkg;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_WR,
    ST_RESP
  } state_e;

  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam logic [7:0] OPC_LD   = 8'h10;
  localparam logic [7:0] OPC_JUMP = 8'h64;
  localparam logic [7:0] OPC_CALL = 8'h80;
  localparam logic [7:0] OPC_RET  = 8'h81;
  localparam logic [7:0] OPC_SVC  = 8'hF0;

  function automatic logic two_word(input logic [7:0] op8);
    case (op8)
      OPC_LD, 8'h11, 8'h12,
      8'h20, 8'h21, 8'h22, 8'h23,
      8'h30, 8'h31, 8'h32,
      8'h40, 8'h41,
      8'h50, 8'h51, 8'h52, 8'h53,
      8'h61, 8'h62, 8'h63, OPC_JUMP, 8'h65, 8'h66,
      8'h70, OPC_CALL, OPC_SVC: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic logic legal(input logic [7:0] op8);
    case (op8)
      OPC_NOP, 8'h14,
      8'h24, 8'h25, 8'h26, 8'h27,
      8'h34, 8'h35, 8'h36,
      8'h44, 8'h45,
      8'h71, OPC_RET: return 1'b1;
      default:        return two_word(op8);
    endcase
  endfunction

endpackage

// File: rtl/comet2_mem_master_if.sv
// CPU request/response channel and RAM strobe bundle seen by the memory master.
interface comet2_mem_master_if;
  logic        cpu_req;
  logic        cpu_ready;
  logic [1:0]  cpu_op;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        resp_valid;
  logic [15:0] resp_word1;
  logic [15:0] resp_word2;
  logic        resp_len;
  logic        resp_illegal;
  logic        resp_err;
  logic        re;
  logic [15:0] raddr;
  logic [15:0] rdata;
  logic        we;
  logic [15:0] waddr;
  logic [15:0] wdata;

  modport master (
    input  cpu_req, cpu_op, cpu_addr, cpu_wdata, rdata,
    output cpu_ready, resp_valid, resp_word1, resp_word2, resp_len,
           resp_illegal, resp_err, re, raddr, we, waddr, wdata
  );

  modport slave (
    output cpu_req, cpu_op, cpu_addr, cpu_wdata, rdata,
    input  cpu_ready, resp_valid, resp_word1, resp_word2, resp_len,
           resp_illegal, resp_err, re, raddr, we, waddr, wdata
  );
endinterface

// File: rtl/comet2_mem_master_ilen_decode.sv
// Instruction-length / legality decode of a COMET II opcode byte.
module comet2_ilen_decode
  import comet2_pkg::*;
(
  input  logic [7:0] op8,
  output logic       is_two_word,
  output logic       is_legal
);
  assign is_two_word = two_word(op8);
  assign is_legal    = legal(op8);
endmodule

// File: rtl/comet2_mem_master.sv
// COMET II CPU-side bus initiator: turns FETCH/LOAD/STORE requests into RAM
// read/write strobes and returns a one-cycle registered response.
module comet2_mem_master
  import comet2_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
)
(
  input logic                 mclk,
  input logic                 rst_n,
  comet2_mem_master_if.master bus
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [15:0] addr_q, addr_d, wdat_q, wdat_d, w1_q, w1_d, w2_q, w2_d;
  logic        err_q, err_d, len_q, len_d, ill_q, ill_d;
  logic        ready_q, re_q, we_q, rv_q, rlen_q, rill_q, rerr_q;
  logic [15:0] raddr_q, waddr_q, wdata_q, rw1_q, rw2_q;
  logic        is_two, is_legal;

  function automatic logic in_range(input logic [15:0] a);
    return {16'h0000, a} < MEM_WORDS;
  endfunction

  comet2_ilen_decode u_ilen (
    .op8         (bus.rdata[15:8]),
    .is_two_word (is_two),
    .is_legal    (is_legal)
  );

  // A rejected address still spends one slot in RD1 (strobes masked) so every
  // single-word transaction answers with the same latency.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    err_d   = err_q;
    len_d   = len_q;
    ill_d   = ill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req && ready_q) begin
          op_d   = (bus.cpu_op == OP_RSVD) ? OP_LOAD : op_e'(bus.cpu_op);
          addr_d = bus.cpu_addr;
          wdat_d = bus.cpu_wdata;
          w1_d   = '0;
          w2_d   = '0;
          len_d  = 1'b0;
          ill_d  = 1'b0;
          err_d  = !in_range(bus.cpu_addr);
          state_d = (op_d == OP_STORE && !err_d) ? ST_WR : ST_RD1;
        end
      end
      ST_RD1: begin
        state_d = ST_RESP;
        if (!err_q) begin
          w1_d = bus.rdata;
          if (op_q == OP_FETCH) begin
            ill_d = !is_legal;
            if (is_two) begin
              if (in_range(addr_q + 16'd1)) begin
                state_d = ST_RD2;
                len_d   = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end
      end
      ST_RD2: begin
        w2_d    = bus.rdata;
        state_d = ST_RESP;
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_FETCH;
      addr_q  <= '0;
      wdat_q  <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      err_q   <= 1'b0;
      len_q   <= 1'b0;
      ill_q   <= 1'b0;
      ready_q <= 1'b1;
      re_q    <= 1'b0;
      raddr_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rv_q    <= 1'b0;
      rw1_q   <= '0;
      rw2_q   <= '0;
      rlen_q  <= 1'b0;
      rill_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      err_q   <= err_d;
      len_q   <= len_d;
      ill_q   <= ill_d;
      // Outputs are registered from the next state so they line up with it.
      ready_q <= (state_d == ST_IDLE);
      re_q    <= (state_d == ST_RD1 && !err_d) || (state_d == ST_RD2);
      raddr_q <= (state_d == ST_RD2) ? addr_d + 16'd1 :
                 (state_d == ST_RD1 && !err_d) ? addr_d : 16'h0000;
      we_q    <= (state_d == ST_WR);
      waddr_q <= (state_d == ST_WR) ? addr_d : 16'h0000;
      wdata_q <= (state_d == ST_WR) ? wdat_d : 16'h0000;
      rv_q    <= (state_d == ST_RESP);
      rw1_q   <= (state_d == ST_RESP) ? w1_d : 16'h0000;
      rw2_q   <= (state_d == ST_RESP) ? w2_d : 16'h0000;
      rlen_q  <= (state_d == ST_RESP) && len_d;
      rill_q  <= (state_d == ST_RESP) && ill_d;
      rerr_q  <= (state_d == ST_RESP) && err_d;
    end
  end

  assign bus.cpu_ready    = ready_q;
  assign bus.re           = re_q;
  assign bus.raddr        = raddr_q;
  assign bus.we           = we_q;
  assign bus.waddr        = waddr_q;
  assign bus.wdata        = wdata_q;
  assign bus.resp_valid   = rv_q;
  assign bus.resp_word1   = rw1_q;
  assign bus.resp_word2   = rw2_q;
  assign bus.resp_len     = rlen_q;
  assign bus.resp_illegal = rill_q;
  assign bus.resp_err     = rerr_q;

endmodule

// File: tb/tb_comet2_mem_master.sv
// Directed bench for comet2_mem_master: a 256-word instance and a 64K-word
// instance, each backed by a behavioural RAM that writes on the falling edge.
module tb_comet2_mem_master;
  import comet2_pkg::*;

  logic mclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 mclk = ~mclk;

  comet2_mem_master_if bus_a ();
  comet2_mem_master_if bus_b ();

  comet2_mem_master #(.MEM_WORDS(256))   dut_a (.mclk(mclk), .rst_n(rst_n), .bus(bus_a));
  comet2_mem_master #(.MEM_WORDS(65536)) dut_b (.mclk(mclk), .rst_n(1'b1),  .bus(bus_b));

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:65535];
  assign bus_a.rdata = bus_a.re ? mem_a[bus_a.raddr[7:0]] : 16'h0000;
  assign bus_b.rdata = bus_b.re ? mem_b[bus_b.raddr] : 16'h0000;

  int checks = 0;
  int errors = 0;
  int re_a = 0, we_a = 0, rv_a = 0, both_a = 0, both_b = 0;
  logic [15:0] last_waddr = '0, last_wdata = '0;
  logic [15:0] raddr_log_b [$];

  // RAM model plus activity monitors, sampled mid-cycle.
  always @(negedge mclk) begin
    static bit loaded = 1'b0;
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem_a[i] = 16'h0000;
      for (int i = 0; i < 65536; i++) mem_b[i] = 16'h0000;
      mem_a[8'h00] = 16'h1270;
      mem_a[8'h01] = 16'h0070;
      mem_a[8'h08] = 16'h2401;
      mem_a[8'hFF] = 16'h6400;
      mem_b[16'hFFFF] = 16'h6100;
      mem_b[16'h0000] = 16'h0013;
      mem_b[16'h0010] = 16'h9000;
      loaded = 1'b1;
    end
    if (bus_a.we) begin
      mem_a[bus_a.waddr[7:0]] = bus_a.wdata;
      last_waddr = bus_a.waddr;
      last_wdata = bus_a.wdata;
      we_a++;
    end
    if (bus_b.we) mem_b[bus_b.waddr] = bus_b.wdata;
    if (bus_a.re) re_a++;
    if (bus_a.resp_valid) rv_a++;
    if (bus_a.re && bus_a.we) both_a++;
    if (bus_b.re && bus_b.we) both_b++;
    if (bus_b.re) raddr_log_b.push_back(bus_b.raddr);
  end

  int          lat;
  logic [15:0] r_w1, r_w2;
  logic        r_len, r_ill, r_err, r_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit sel_b, input logic [1:0] op,
                       input logic [15:0] addr, input logic [15:0] wd);
    @(negedge mclk);
    if (sel_b) begin
      bus_b.cpu_req = 1'b1; bus_b.cpu_op = op; bus_b.cpu_addr = addr; bus_b.cpu_wdata = wd;
    end else begin
      bus_a.cpu_req = 1'b1; bus_a.cpu_op = op; bus_a.cpu_addr = addr; bus_a.cpu_wdata = wd;
    end
    @(posedge mclk);
    #1;
    bus_a.cpu_req = 1'b0;
    bus_b.cpu_req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge mclk);
      if (sel_b ? bus_b.resp_valid : bus_a.resp_valid) begin
        lat   = k;
        r_w1  = sel_b ? bus_b.resp_word1   : bus_a.resp_word1;
        r_w2  = sel_b ? bus_b.resp_word2   : bus_a.resp_word2;
        r_len = sel_b ? bus_b.resp_len     : bus_a.resp_len;
        r_ill = sel_b ? bus_b.resp_illegal : bus_a.resp_illegal;
        r_err = sel_b ? bus_b.resp_err     : bus_a.resp_err;
        r_rdy = sel_b ? bus_b.cpu_ready    : bus_a.cpu_ready;
        break;
      end
    end
  endtask

  int re0, we0, rv0, lg0;

  initial begin
    bus_a.cpu_req = 1'b0; bus_a.cpu_op = 2'b00; bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0;
    bus_b.cpu_req = 1'b0; bus_b.cpu_op = 2'b00; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    chk("rst_ready", 32'(bus_a.cpu_ready), 32'h1);
    chk("rst_re_we", {bus_a.re, bus_a.we}, 32'h0);
    chk("rst_addrs", {bus_a.raddr, bus_a.waddr}, 32'h0);
    chk("rst_wdata", 32'(bus_a.wdata), 32'h0);
    chk("rst_resp", {bus_a.resp_valid, bus_a.resp_word1, bus_a.resp_len,
                     bus_a.resp_illegal, bus_a.resp_err}, 32'h0);
    rst_n = 1'b1;

    // Two-word FETCH
    re0 = re_a;
    issue(1'b0, 2'b00, 16'h0000, 16'h0000);
    chk("f2_lat", lat, 32'd3);
    chk("f2_w1", r_w1, 32'h1270);
    chk("f2_w2", r_w2, 32'h0070);
    chk("f2_len_ill", {r_len, r_ill}, 32'h2);
    chk("f2_ready_in_resp", 32'(r_rdy), 32'h0);
    chk("f2_re_cycles", re_a - re0, 32'd2);

    // One-word FETCH
    re0 = re_a;
    issue(1'b0, 2'b00, 16'h0008, 16'h0000);
    chk("f1_lat", lat, 32'd2);
    chk("f1_w1", r_w1, 32'h2401);
    chk("f1_w2_len", {r_w2, r_len}, 32'h0);
    chk("f1_re_cycles", re_a - re0, 32'd1);

    // STORE then LOAD back
    we0 = we_a;
    issue(1'b0, 2'b10, 16'h0080, 16'hBEEF);
    chk("st_lat", lat, 32'd2);
    chk("st_we_cycles", we_a - we0, 32'd1);
    chk("st_waddr_wdata", {last_waddr, last_wdata}, 32'h0080BEEF);
    chk("st_w1", r_w1, 32'h0);
    issue(1'b0, 2'b01, 16'h0080, 16'h0000);
    chk("ld_lat", lat, 32'd2);
    chk("ld_w1", r_w1, 32'hBEEF);
    chk("ld_err_ill", {r_err, r_ill}, 32'h0);

    // Reserved op behaves as LOAD
    issue(1'b0, 2'b11, 16'h0008, 16'h0000);
    chk("rsvd_w1", r_w1, 32'h2401);
    chk("rsvd_len", 32'(r_len), 32'h0);

    // Out-of-range LOAD, and FETCH whose second word falls off the end
    re0 = re_a; we0 = we_a;
    issue(1'b0, 2'b01, 16'h0100, 16'h0000);
    chk("oor_lat", lat, 32'd2);
    chk("oor_err", 32'(r_err), 32'h1);
    chk("oor_no_strobes", (re_a - re0) + (we_a - we0), 32'd0);
    re0 = re_a;
    issue(1'b0, 2'b00, 16'h00FF, 16'h0000);
    chk("edge_err", 32'(r_err), 32'h1);
    chk("edge_w1", r_w1, 32'h6400);
    chk("edge_lat", lat, 32'd2);
    chk("edge_re_cycles", re_a - re0, 32'd1);

    // 64K instance: address wrap and illegal opcode
    lg0 = raddr_log_b.size();
    issue(1'b1, 2'b00, 16'hFFFF, 16'h0000);
    chk("wrap_lat", lat, 32'd3);
    chk("wrap_w1_w2", {r_w1, r_w2}, 32'h61000013);
    chk("wrap_len_err", {r_len, r_err}, 32'h2);
    chk("wrap_reads", raddr_log_b.size() - lg0, 32'd2);
    if (raddr_log_b.size() - lg0 == 2) begin
      chk("wrap_raddr", {raddr_log_b[lg0], raddr_log_b[lg0 + 1]}, 32'hFFFF0000);
    end
    issue(1'b1, 2'b00, 16'h0010, 16'h0000);
    chk("ill_flags", {r_ill, r_len}, 32'h2);
    chk("ill_lat", lat, 32'd2);

    // Reset while in RD2 drops the request
    rv0 = rv_a;
    @(negedge mclk);
    bus_a.cpu_req = 1'b1; bus_a.cpu_op = 2'b00; bus_a.cpu_addr = 16'h0000;
    @(posedge mclk);
    #1;
    bus_a.cpu_req = 1'b0;
    @(negedge mclk);
    @(negedge mclk);
    chk("rd2_reached", {bus_a.re, bus_a.raddr}, 32'h10001);
    rst_n = 1'b0;
    @(negedge mclk);
    chk("mid_rst_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    chk("mid_rst_ready_re", {bus_a.cpu_ready, bus_a.re}, 32'h2);
    rst_n = 1'b1;
    repeat (5) @(negedge mclk);
    chk("mid_rst_no_resp", rv_a - rv0, 32'd0);

    chk("re_we_exclusive", both_a + both_b, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
